// File: rtl/mips_top.sv
// Switch calculator for the FPGA demo board: two 32-bit operands from DIP switches,
// op from user keys, result on LEDs and hex tubes. Define MIPS_DIV_EN to build the divider.
module mips_top #(
    parameter int SCAN_DIV = 1024
) (
    input  logic        clk_in,
    input  logic        sys_rstn,
    input  logic [7:0]  dip_switch0,
    input  logic [7:0]  dip_switch1,
    input  logic [7:0]  dip_switch2,
    input  logic [7:0]  dip_switch3,
    input  logic [7:0]  dip_switch4,
    input  logic [7:0]  dip_switch5,
    input  logic [7:0]  dip_switch6,
    input  logic [7:0]  dip_switch7,
    input  logic [7:0]  user_key,
    output logic [31:0] led_light,
    output logic [7:0]  digital_tube0,
    output logic [3:0]  digital_tube_sel0,
    output logic [7:0]  digital_tube1,
    output logic [3:0]  digital_tube_sel1,
    output logic [7:0]  digital_tube2,
    output logic        digital_tube_sel2
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [63:0] sw_meta, sw_sync;
    logic [7:0]  key_meta, key_sync;
    logic [31:0] a, b, alu, result;
    logic [2:0]  op, key_idx;
    logic        key_hit;

    // Synchronizers idle high, so operands read as 0 and no key is pressed out of reset.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sw_meta  <= '1;
            sw_sync  <= '1;
            key_meta <= '1;
            key_sync <= '1;
        end else begin
            sw_meta  <= {dip_switch7, dip_switch6, dip_switch5, dip_switch4,
                         dip_switch3, dip_switch2, dip_switch1, dip_switch0};
            sw_sync  <= sw_meta;
            key_meta <= user_key;
            key_sync <= key_meta;
        end
    end

    assign a = ~sw_sync[31:0];
    assign b = ~sw_sync[63:32];

    always_comb begin
        key_hit = 1'b0;
        key_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (!key_sync[i]) begin
                key_hit = 1'b1;
                key_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn)    op <= '0;
        else if (key_hit) op <= key_idx;
    end

    always_comb begin
        case (op)
            3'd0:    alu = a + b;
            3'd1:    alu = a - b;
            3'd2:    alu = a * b;
            3'd5:    alu = a & b;
            3'd6:    alu = a | b;
            3'd7:    alu = a ^ b;
            default: alu = '0;
        endcase
    end

`ifdef MIPS_DIV_EN
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    logic [1:0]  div_state;
    logic [4:0]  div_cnt;
    logic [31:0] div_quo, div_rem, div_den, rem_next;
    logic [32:0] rem_sh, rem_sub;
    logic        is_div, rem_ge;

    assign is_div = (op == 3'd3) || (op == 3'd4);

    // Restoring step; a zero divisor naturally yields all-ones quotient and remainder A.
    assign rem_sh   = {div_rem, div_quo[31]};
    assign rem_ge   = rem_sh >= {1'b0, div_den};
    assign rem_sub  = rem_sh - {1'b0, div_den};
    assign rem_next = rem_ge ? rem_sub[31:0] : rem_sh[31:0];

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            div_state <= DIV_IDLE;
            div_cnt   <= '0;
            div_quo   <= '0;
            div_rem   <= '0;
            div_den   <= '0;
        end else if (!is_div) begin
            div_state <= DIV_IDLE;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    div_quo   <= a;
                    div_den   <= b;
                    div_rem   <= '0;
                    div_cnt   <= '0;
                    div_state <= DIV_RUN;
                end
                DIV_RUN: begin
                    div_quo <= {div_quo[30:0], rem_ge};
                    div_rem <= rem_next;
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31) div_state <= DIV_DONE;
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn)                  result <= '0;
        else if (!is_div)               result <= alu;
        else if (div_state == DIV_DONE) result <= (op == 3'd3) ? div_quo : div_rem;
    end
`else
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) result <= '0;
        else           result <= alu;
    end
`endif

    assign led_light = ~result;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 8'hC0;  4'h1: hex_seg = 8'hF9;
            4'h2: hex_seg = 8'hA4;  4'h3: hex_seg = 8'hB0;
            4'h4: hex_seg = 8'h99;  4'h5: hex_seg = 8'h92;
            4'h6: hex_seg = 8'h82;  4'h7: hex_seg = 8'hF8;
            4'h8: hex_seg = 8'h80;  4'h9: hex_seg = 8'h90;
            4'hA: hex_seg = 8'h88;  4'hB: hex_seg = 8'h83;
            4'hC: hex_seg = 8'hC6;  4'hD: hex_seg = 8'hA1;
            4'hE: hex_seg = 8'h86;  default: hex_seg = 8'h8E;
        endcase
    endfunction

    logic [CW-1:0] scan_cnt;
    logic [1:0]    scan_idx;

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == CNT_MAX) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Segments and selects come from the same index so they switch on the same edge.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            digital_tube0     <= 8'hFF;
            digital_tube1     <= 8'hFF;
            digital_tube2     <= 8'hFF;
            digital_tube_sel0 <= '0;
            digital_tube_sel1 <= '0;
            digital_tube_sel2 <= 1'b0;
        end else begin
            digital_tube0     <= hex_seg(result[{scan_idx, 2'b00} +: 4]);
            digital_tube1     <= hex_seg(result[{1'b1, scan_idx, 2'b00} +: 4]);
            digital_tube2     <= hex_seg({1'b0, op});
            digital_tube_sel0 <= 4'b0001 << scan_idx;
            digital_tube_sel1 <= 4'b0001 << scan_idx;
            digital_tube_sel2 <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mips_top.sv
// Randomized self-checking bench for mips_top against a plain-arithmetic calculator model.
module tb_mips_top;
    localparam int SCAN_DIV = 4;

    logic        clk_in = 1'b0;
    logic        sys_rstn = 1'b0;
    logic [7:0]  dip_switch0, dip_switch1, dip_switch2, dip_switch3;
    logic [7:0]  dip_switch4, dip_switch5, dip_switch6, dip_switch7;
    logic [7:0]  user_key;
    logic [31:0] led_light;
    logic [7:0]  digital_tube0, digital_tube1, digital_tube2;
    logic [3:0]  digital_tube_sel0, digital_tube_sel1;
    logic        digital_tube_sel2;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned cyc;

    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    mips_top #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk_in(clk_in), .sys_rstn(sys_rstn),
        .dip_switch0(dip_switch0), .dip_switch1(dip_switch1),
        .dip_switch2(dip_switch2), .dip_switch3(dip_switch3),
        .dip_switch4(dip_switch4), .dip_switch5(dip_switch5),
        .dip_switch6(dip_switch6), .dip_switch7(dip_switch7),
        .user_key(user_key), .led_light(led_light),
        .digital_tube0(digital_tube0), .digital_tube_sel0(digital_tube_sel0),
        .digital_tube1(digital_tube1), .digital_tube_sel1(digital_tube_sel1),
        .digital_tube2(digital_tube2), .digital_tube_sel2(digital_tube_sel2)
    );

    always #5 clk_in = ~clk_in;

    // Edges since reset release; digit k-th edge shows index ((k-1)/SCAN_DIV)%4.
    always @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input int op);
        case (op)
            0: model = a + b;
            1: model = a - b;
            2: model = a * b;
`ifdef MIPS_DIV_EN
            3: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4: model = (b == 0) ? a : a % b;
`else
            3: model = 32'h0;
            4: model = 32'h0;
`endif
            5: model = a & b;
            6: model = a | b;
            default: model = a ^ b;
        endcase
    endfunction

    task automatic set_ab(input logic [31:0] a, input logic [31:0] b);
        {dip_switch3, dip_switch2, dip_switch1, dip_switch0} = ~a;
        {dip_switch7, dip_switch6, dip_switch5, dip_switch4} = ~b;
    endtask

    // Apply operands and keys together, release keys, then allow the worst-case divide latency.
    task automatic run_op(input string tag, input logic [7:0] keys, input int op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        set_ab(a, b);
        user_key = ~keys;
        repeat (4) @(posedge clk_in);
        user_key = 8'hFF;
        repeat (67) @(posedge clk_in);
        @(negedge clk_in);
        exp = model(a, b, op);
        chk({tag, ".led"}, led_light, ~exp);
        chk({tag, ".tube2"}, {24'h0, digital_tube2}, {24'h0, font[op]});
    endtask

    task automatic check_scan(input string tag, input logic [31:0] exp);
        int i;
        logic [3:0] sel_exp;
        repeat (4 * SCAN_DIV) begin
            @(negedge clk_in);
            i = int'(((cyc - 1) / SCAN_DIV) % 4);
            sel_exp = 4'b0001 << i;
            chk({tag, ".sel0"}, {28'h0, digital_tube_sel0}, {28'h0, sel_exp});
            chk({tag, ".sel1"}, {28'h0, digital_tube_sel1}, {28'h0, sel_exp});
            chk({tag, ".seg0"}, {24'h0, digital_tube0}, {24'h0, font[exp[4*i +: 4]]});
            chk({tag, ".seg1"}, {24'h0, digital_tube1}, {24'h0, font[exp[16+4*i +: 4]]});
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [7:0]  hi_keys, ff;
        int rop;

        user_key = 8'hFF;
        set_ab(32'h0, 32'h0);
        sys_rstn = 1'b0;
        #1000;
        chk("rst.led", led_light, 32'hFFFF_FFFF);
        chk("rst.sel0", {28'h0, digital_tube_sel0}, 32'h0);
        chk("rst.sel1", {28'h0, digital_tube_sel1}, 32'h0);
        chk("rst.sel2", {31'h0, digital_tube_sel2}, 32'h0);
        chk("rst.seg0", {24'h0, digital_tube0}, 32'hFF);
        chk("rst.seg1", {24'h0, digital_tube1}, 32'hFF);
        chk("rst.seg2", {24'h0, digital_tube2}, 32'hFF);

        @(negedge clk_in);
        sys_rstn = 1'b1;
        @(negedge clk_in);
        chk("first.sel0", {28'h0, digital_tube_sel0}, 32'h1);
        chk("first.sel1", {28'h0, digital_tube_sel1}, 32'h1);
        chk("first.sel2", {31'h0, digital_tube_sel2}, 32'h1);
        chk("first.seg0", {24'h0, digital_tube0}, 32'hC0);
        chk("first.seg2", {24'h0, digital_tube2}, 32'hC0);

        run_op("add", 8'h01, 0, 32'd123, 32'd124324);
        chk("add.lit", led_light, 32'hFFFE_19E0);
        check_scan("add.scan", 32'h0001_E61F);
        run_op("sub", 8'h02, 1, 32'd123, 32'd124324);
        chk("sub.lit", led_light, ~32'hFFFE_1AD7);
        repeat (10) @(posedge clk_in);
        @(negedge clk_in);
        chk("sub.held", led_light, ~32'hFFFE_1AD7);
        chk("sub.tube2", {24'h0, digital_tube2}, 32'hF9);
        run_op("mul", 8'h04, 2, 32'd123, 32'd124324);
        chk("mul.lit", led_light, ~32'h00E9_55CC);
        run_op("pri05", 8'h21, 0, 32'd123, 32'd124324);
        run_op("div", 8'h08, 3, 32'd124324, 32'd123);
        run_op("mod", 8'h10, 4, 32'd124324, 32'd123);
        run_op("div0", 8'h08, 3, 32'd124324, 32'd0);
        run_op("mod0", 8'h10, 4, 32'd124324, 32'd0);
        check_scan("mod0.scan", model(32'd124324, 32'd0, 4));

        ff = 8'hFF;
        for (int it = 0; it < 24; it++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'h0;
                1:       rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            rop = $urandom_range(0, 7);
            hi_keys = 8'($urandom) & (ff << (rop + 1));
            run_op("rnd", (8'h01 << rop) | hi_keys, rop, ra, rb);
            if (it % 6 == 0) check_scan("rnd.scan", model(ra, rb, rop));
        end

        // Reset in the middle of a divide run.
        set_ab(32'd124324, 32'd123);
        user_key = ~8'h08;
        repeat (20) @(posedge clk_in);
        @(negedge clk_in);
        sys_rstn = 1'b0;
        user_key = 8'hFF;
        #1;
        chk("mid.led", led_light, 32'hFFFF_FFFF);
        chk("mid.sel0", {28'h0, digital_tube_sel0}, 32'h0);
        chk("mid.seg0", {24'h0, digital_tube0}, 32'hFF);
        repeat (3) @(negedge clk_in);
        sys_rstn = 1'b1;
        repeat (6) @(posedge clk_in);
        @(negedge clk_in);
        chk("mid.post", led_light, ~(32'd124324 + 32'd123));
        chk("mid.op0", {24'h0, digital_tube2}, 32'hC0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
